// File: rtl/midi_encoder_if.sv
// Handshake bundle between a MIDI message/real-time source, the encoder and a
// byte-wide transmitter: message, real-time and tx byte channels plus the error pulse.
interface midi_encoder_if;
  logic        msg_valid;
  logic [23:0] msg_data;
  logic [1:0]  msg_len;
  logic        msg_ready;
  logic        rt_valid;
  logic [7:0]  rt_code;
  logic        rt_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        err;

  modport slave (
    input  msg_valid, msg_data, msg_len, rt_valid, rt_code, tx_ready,
    output msg_ready, rt_ready, tx_valid, tx_data, err
  );

  modport master (
    output msg_valid, msg_data, msg_len, rt_valid, rt_code, tx_ready,
    input  msg_ready, rt_ready, tx_valid, tx_data, err
  );
endinterface

// File: rtl/midi_encoder.sv
// MIDI message to byte-stream encoder with real-time byte injection and error flagging.
// Optional feature macro: MIDI_RUNNING_STATUS_EN (running-status compression + idle refresh).
module midi_encoder #(
  parameter int RS_REFRESH = 4096,
  parameter int CNT_W      = $clog2(RS_REFRESH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  midi_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_STATUS = 2'd1,
    SEND_D1     = 2'd2,
    SEND_D2     = 2'd3
  } state_t;

  state_t      state_r;
  logic [23:0] data_r;
  logic [1:0]  len_r;
  logic        tx_valid_r;
  logic [7:0]  tx_data_r;
  logic        err_r;

  logic        slot_free_s;
  logic        rt_take_s;
  logic        accept_s;
  logic        malformed_s;
  logic        good_accept_s;
  logic        rt_status_s;
  logic [1:0]  eff_len_s;
  logic        data_bad_s;
  logic        suppress_s;
  state_t      cur_state_s;
  logic [23:0] cur_data_s;
  logic [1:0]  cur_len_s;
  logic        msg_load_s;
  logic [7:0]  load_byte_s;
  state_t      next_state_s;

  function automatic state_t after_load(input state_t st, input logic [1:0] len);
    state_t nxt;
    case (st)
      SEND_STATUS: nxt = (len > 2'd1) ? SEND_D1 : IDLE;
      SEND_D1:     nxt = (len == 2'd3) ? SEND_D2 : IDLE;
      default:     nxt = IDLE;
    endcase
    return nxt;
  endfunction

  // Data bytes always go out with bit7 cleared so a stray status bit cannot corrupt the stream.
  function automatic logic [7:0] byte_of(input state_t st, input logic [23:0] d);
    logic [7:0] b;
    case (st)
      SEND_STATUS: b = d[7:0];
      SEND_D1:     b = d[15:8] & 8'h7F;
      SEND_D2:     b = d[23:16] & 8'h7F;
      default:     b = 8'h00;
    endcase
    return b;
  endfunction

  assign slot_free_s   = !tx_valid_r || bus.tx_ready;
  assign rt_take_s     = slot_free_s && bus.rt_valid;
  assign accept_s      = bus.msg_valid && (state_r == IDLE);
  assign malformed_s   = (bus.msg_len == 2'd0) || !bus.msg_data[7];
  assign good_accept_s = accept_s && !malformed_s;
  assign rt_status_s   = (bus.msg_data[7:0] >= 8'hF8);
  assign eff_len_s     = rt_status_s ? 2'd1 : bus.msg_len;
  assign data_bad_s    = ((eff_len_s >= 2'd2) && bus.msg_data[15]) ||
                         ((eff_len_s == 2'd3) && bus.msg_data[23]);

`ifdef MIDI_RUNNING_STATUS_EN
  localparam int             CW        = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [CW-1:0]  REFRESH_C = CW'(RS_REFRESH);

  logic [7:0]    last_status_r;
  logic [CW-1:0] idle_cnt_r;
  logic          expired_s;
  logic          channel_s;

  assign expired_s  = (RS_REFRESH != 0) && (idle_cnt_r == REFRESH_C);
  assign channel_s  = bus.msg_data[7] && (bus.msg_data[7:4] != 4'hF);
  // A 1-byte channel message keeps its status, otherwise nothing would be sent at all.
  assign suppress_s = channel_s && (eff_len_s > 2'd1) && !expired_s &&
                      (bus.msg_data[7:0] == last_status_r);

  // Idle counter and remembered running status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_r    <= {CW{1'b0}};
      last_status_r <= 8'h00;
    end else begin
      if (rt_take_s || msg_load_s) begin
        idle_cnt_r <= {CW{1'b0}};
      end else if (idle_cnt_r != REFRESH_C) begin
        idle_cnt_r <= idle_cnt_r + CW'(1);
      end
      if (good_accept_s && channel_s) begin
        last_status_r <= bus.msg_data[7:0];
      end else if (good_accept_s && !rt_status_s) begin
        last_status_r <= 8'h00;
      end else if (expired_s) begin
        last_status_r <= 8'h00;
      end
    end
  end
`else
  localparam int unused_cfg = RS_REFRESH + CNT_W;
  assign suppress_s = 1'b0;
`endif

  // Resolve which byte (fresh message or latched one) competes for the output slot.
  always_comb begin
    cur_state_s = state_r;
    cur_data_s  = data_r;
    cur_len_s   = len_r;
    if (good_accept_s) begin
      cur_state_s = suppress_s ? SEND_D1 : SEND_STATUS;
      cur_data_s  = bus.msg_data;
      cur_len_s   = eff_len_s;
    end else begin
      cur_state_s = state_r;
    end
    msg_load_s   = slot_free_s && !bus.rt_valid && (cur_state_s != IDLE);
    load_byte_s  = byte_of(cur_state_s, cur_data_s);
    next_state_s = msg_load_s ? after_load(cur_state_s, cur_len_s) : cur_state_s;
  end

  // FSM, message latch, output slot and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      data_r     <= 24'h000000;
      len_r      <= 2'd0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
      err_r      <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (good_accept_s) begin
        data_r <= bus.msg_data;
        len_r  <= eff_len_s;
      end
      if (rt_take_s) begin
        tx_data_r  <= bus.rt_code;
        tx_valid_r <= 1'b1;
      end else if (msg_load_s) begin
        tx_data_r  <= load_byte_s;
        tx_valid_r <= 1'b1;
      end else if (slot_free_s) begin
        tx_valid_r <= 1'b0;
      end
      err_r <= accept_s && (malformed_s || data_bad_s);
    end
  end

  assign bus.msg_ready = (state_r == IDLE);
  assign bus.rt_ready  = rt_take_s;
  assign bus.tx_valid  = tx_valid_r;
  assign bus.tx_data   = tx_data_r;
  assign bus.err       = err_r;

endmodule

// File: doc/midi_encoder.md
Name: midi_encoder

Overview:
- Converts parsed MIDI messages and out-of-band real-time codes into a serial MIDI byte stream. This is the transmit counterpart of the MIDI parser.
- Sits between the synth control logic or MIDI thru path and the UART transmitter.
- Applies running-status compression.
- Injects real-time bytes between message bytes with priority.
- Flags malformed messages.

Parameters:
RS_REFRESH, 4096, idle cycles with no byte output after which running status is forgotten; 0 = never forget
CNT_W, $clog2(RS_REFRESH+1), width of the idle counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
msg_valid  in  1  message offered
msg_data  in  24  byte0 in [7:0] (status), byte1 in [15:8], byte2 in [23:16]
msg_len  in  2  number of valid bytes, 1..3
msg_ready  out  1  encoder accepts message this cycle
rt_valid  in  1  real-time code offered (F8/FA/FB/FC/FE/FF)
rt_code  in  8  real-time byte
rt_ready  out  1  real-time code accepted this cycle
tx_valid  out  1  output byte valid
tx_data  out  8  output byte
tx_ready  in  1  downstream (UART) takes byte
err  out  1  one-cycle pulse on malformed message

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. Reset values:
  - tx_valid=0, tx_data=8'h00, err=0.
  - FSM=IDLE, last_status=8'h00 (invalid), idle counter=0.
  - msg_ready=1 and rt_ready follows the slot rule below.
- Output register:
  - tx_data/tx_valid hold stable while tx_valid && !tx_ready.
  - Slot is free when !tx_valid || tx_ready.
  - On a free slot with nothing to load, tx_valid goes to 0 next cycle.
- msg_ready = (state==IDLE). A message is accepted when msg_valid && msg_ready. Accepted bytes and msg_len are latched.
- Real-time priority:
  - If the slot is free and rt_valid=1, rt_code is loaded in preference to any pending message byte.
  - rt_ready=1 exactly in that cycle; otherwise rt_ready=0.
  - Real-time codes never alter last_status or the FSM.
  - A message byte pending in the same cycle waits one slot.
- FSM states: IDLE, SEND_STATUS, SEND_D1, SEND_D2.
  - IDLE: on accept, go to SEND_STATUS; if the status byte is suppressed, go to SEND_D1 instead.
  - SEND_STATUS: on loading the status byte into the slot, go to SEND_D1 if len>1, else IDLE.
  - SEND_D1: on load, go to SEND_D2 if len==3, else IDLE.
  - SEND_D2: on load, go to IDLE.
- Latency: a message accepted in cycle N presents its first byte with tx_valid=1 in cycle N+1, given a free slot and no rt_valid. A 3-byte message needs a minimum of 3 tx cycles.
- Running status (status 8'h80-8'hEF):
  - The status byte is skipped when it equals last_status, then last_status is updated.
  - Status 8'hF0-8'hF7 is always sent and sets last_status=8'h00.
  - Status >= 8'hF8 arriving on the msg path is sent as a 1-byte message and leaves last_status unchanged.
- Idle counter:
  - Increments each cycle no byte is loaded; it clears on any load.
  - When it reaches RS_REFRESH (RS_REFRESH != 0), last_status is set to 8'h00, so the next channel message resends its status. The counter saturates.
- Malformed message: msg_len==0 or byte0[7]==0.
  - The message is accepted and discarded, with no output.
  - err pulses in the cycle after the accept, and the FSM stays in IDLE.
- Data bytes with bit7=1: the byte is sent with bit7 cleared and err pulses once for that message.
- Back-pressure: with tx_ready held 0, nothing is lost. The FSM stalls, msg_ready=0 and rt_ready=0.
- Reset mid-message: the partial message is abandoned and tx_valid drops immediately (async). The next message always sends its status.

Optional Feature:
MIDI_RUNNING_STATUS_EN
- Defined: running-status compression and the RS_REFRESH idle counter behave as above.
- Undefined: every message sends its status byte; last_status and the idle counter are not implemented; RS_REFRESH is ignored.

Test Plan:
- Note-on 90 3C 64 then 90 3E 50, tx_ready=1 -> stream 90 3C 64 3E 50 with the macro; 90 3C 64 90 3E 50 without it.
- Message 90 3C 64 accepted, rt F8 asserted on the cycle the 3C slot frees -> stream 90 F8 3C 64; rt_ready high for one cycle; second 90-msg still suppressed.
- Program change C1 05 (len 2), then idle RS_REFRESH=16 cycles, then C1 07 -> stream C1 05 C1 07.
- Message B0 07 64, then F2 10 20, then B0 07 50 -> B0 07 64 F2 10 20 B0 07 50; system-common status clears running status.
- Message 3C 64 00 len 2 (no status bit) -> no tx bytes, err pulses one cycle, msg_ready back to 1 next cycle. Data byte 0xC0 in 90 C0 40 -> 90 40 40 plus err.
- tx_ready held 0 for 10 cycles mid-message with rt_valid=1 -> tx_data stable, rt_ready=0. On release, bytes continue in order with the rt code first. Assert rst_n low mid-stream -> tx_valid=0 at once, then next 90 msg sends status.
